// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants, FSM state type and one-hot helper for the round-robin 8:1 mux arbiter.
// No logic of its own; imported by rr_pick8 and rr_mux_arbiter.
package rr_mux_arbiter_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot8(input logic [SEL_W-1:0] s);
    return NUM_REQ'(1) << s;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Round-robin search over 8 requests starting at ptr and wrapping 7->0.
// Purely combinational, zero latency; no flow control of its own.
module rr_pick8
  import rr_mux_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  // Scan from the farthest offset down so the nearest active request to ptr wins.
  always_comb begin
    any  = |req;
    idx  = '0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter + registered 8:1 data mux; grant 1 cycle after req seen in IDLE, ack 1 cycle after accept.
// Holds out_data/out_sel while out_ready is low; one IDLE bubble between transfers.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   d,
  output logic [N-1:0]     ack,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_sel
);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic [W-1:0]     slot [N];

  for (genvar i = 0; i < N; i++) begin : g_slot
    assign slot[i] = d[i*W +: W];
  end

  rr_pick8 u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ack       <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          if (pick_any) begin
            out_sel   <= pick_idx;
            out_data  <= slot[pick_idx];
            out_valid <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          // req and d are deliberately ignored here so the granted word stays frozen.
          if (out_ready) begin
            out_valid <= 1'b0;
            ack       <= onehot8(out_sel);
            ptr       <= out_sel + SEL_W'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: single grant, wrap, backpressure, drop, reset, saturation.
module tb_rr_mux_arbiter;

  logic        clk;
  logic        rst_n;
  logic [7:0]  req;
  logic [63:0] d;
  logic [7:0]  ack;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_sel;

  int n_pass;
  int n_total;

  rr_mux_arbiter #(.W(8), .N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .d         (d),
    .ack       (ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_grant(input string tag, input logic [2:0] sel, input logic [7:0] dat);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sel"},   32'(out_sel),   32'(sel));
    chk({tag, "_data"},  32'(out_data),  32'(dat));
    chk({tag, "_ack0"},  32'(ack),       32'd0);
  endtask

  task automatic chk_ack(input string tag, input logic [7:0] mask);
    chk({tag, "_ack"},    32'(ack),       32'(mask));
    chk({tag, "_valid0"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] s;
    n_pass    = 0;
    n_total   = 0;
    rst_n     = 1'b0;
    req       = 8'h00;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'hA0 + 8'(i);

    // Reset state
    tick;
    tick;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ack",   32'(ack),       32'd0);
    chk("rst_sel",   32'(out_sel),   32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    rst_n = 1'b1;
    tick;
    chk("idle_valid", 32'(out_valid), 32'd0);

    // Single request on slot 5
    req       = 8'h20;
    out_ready = 1'b1;
    tick;
    chk_grant("single", 3'd5, 8'hA5);
    tick;
    chk_ack("single", 8'h20);
    req = 8'h00;
    tick;
    chk("single_ack_clear", 32'(ack), 32'd0);

    // Wrap: ptr=6, req 0 and 6 -> 6, 0, 6
    req = 8'h41;
    tick;
    chk_grant("wrap1", 3'd6, 8'hA6);
    tick;
    chk_ack("wrap1", 8'h40);
    tick;
    chk_grant("wrap2", 3'd0, 8'hA0);
    tick;
    chk_ack("wrap2", 8'h01);
    tick;
    chk_grant("wrap3", 3'd6, 8'hA6);
    tick;
    chk_ack("wrap3", 8'h40);
    req = 8'h00;
    tick;

    // Backpressure on slot 3 while data and other requests change
    req       = 8'h08;
    out_ready = 1'b0;
    tick;
    chk_grant("bp_grant", 3'd3, 8'hA3);
    for (int c = 0; c < 5; c++) begin
      d[3*8 +: 8] = 8'h30 + 8'(c);
      req         = 8'h88;
      tick;
      chk_grant("bp_hold", 3'd3, 8'hA3);
    end
    out_ready = 1'b1;
    tick;
    chk_ack("bp", 8'h08);
    req         = 8'h00;
    d[3*8 +: 8] = 8'hA3;
    tick;

    // Drop while granted: ptr=4, grant 2, then req[2] falls
    req       = 8'h04;
    out_ready = 1'b0;
    tick;
    chk_grant("drop_grant", 3'd2, 8'hA2);
    req = 8'h41;
    tick;
    chk_grant("drop_hold", 3'd2, 8'hA2);
    out_ready = 1'b1;
    tick;
    chk_ack("drop", 8'h04);
    tick;
    chk_grant("drop_next", 3'd6, 8'hA6);
    tick;
    chk_ack("drop_next", 8'h40);
    req = 8'h00;
    tick;

    // Reset mid-BUSY: immediate clear, no ack for abandoned word
    req       = 8'h10;
    out_ready = 1'b0;
    tick;
    chk_grant("rb_grant", 3'd4, 8'hA4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rb_valid", 32'(out_valid), 32'd0);
    chk("rb_ack",   32'(ack),       32'd0);
    chk("rb_sel",   32'(out_sel),   32'd0);
    chk("rb_data",  32'(out_data),  32'd0);
    req = 8'h00;
    tick;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick;
    chk("rb_noack1", 32'(ack), 32'd0);
    tick;
    chk("rb_noack2", 32'(ack), 32'd0);
    chk("rb_idle",   32'(out_valid), 32'd0);

    // Saturation from ptr=0: 0..7,0..7 alternating with ack cycles
    req = 8'hFF;
    for (int k = 0; k < 16; k++) begin
      s = 3'(k);
      tick;
      chk_grant("sat", s, 8'hA0 + 8'(s));
      tick;
      chk_ack("sat", 8'h01 << s);
      if (k == 15) req = 8'h00;
    end
    tick;
    chk("end_valid", 32'(out_valid), 32'd0);
    chk("end_ack",   32'(ack),       32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
